z80fi_insn_check: RTL and testbench
===================================

Name: z80fi_insn_check

Overview:
- Checker stage directly downstream of the z80fi instruction spec modules.
- Each cycle, takes the core's retired-instruction packet (z80fi_*) and one spec module's predicted outputs (spec_*), and compares them.
- Two-stage pipeline; reports per-instruction pass/fail, latches the first failure, and counts checked and skipped instructions.
- The formal/sim harness asserts on its outputs.

Parameters:
- COUNT_W, 16, width of check_count and skip_count; both saturate.
- STOP_ON_FAIL, 1, 1 = FSM enters FAILED on first failure and ignores further packets; 0 = keep checking.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- check_enable  in  1  level; arms checking
- check_clear  in  1  pulse; clears sticky failure state, returns FSM to IDLE
- z80fi_valid  in  1  core retired an instruction this cycle
- z80fi_insn  in  32  instruction bytes, first byte in [7:0]
- z80fi_insn_len  in  3  instruction length, bytes
- z80fi_reg_ip_in / z80fi_reg_ip_out  in  16  IP before/after
- z80fi_reg_f_in / z80fi_reg_f_out  in  8  F before/after
- z80fi_reg_a_in / z80fi_reg_a_out  in  8  A before/after
- spec_valid  in  1  spec module claims this instruction
- spec_chk  in  3  {A,F,IP} spec-written mask; wrapper decodes from spec_signals via SPEC_REG_A/F/IP
- spec_reg_ip_out  in  16  predicted IP
- spec_reg_f_out  in  8  predicted F
- spec_reg_a_out  in  8  predicted A
- check_valid  out  1  one-cycle pulse: result available
- check_fail  out  1  qualified by check_valid
- mismatch  out  3  {A,F,IP} mismatch bits, qualified by check_valid
- failed_sticky  out  1  a failure has been seen since reset/clear
- fail_insn  out  32  insn of first failure
- fail_ip  out  16  z80fi_reg_ip_in of first failure
- fail_mask  out  3  mismatch of first failure
- check_count  out  COUNT_W  instructions checked
- skip_count  out  COUNT_W  retired instructions with spec_valid=0
- state  out  2  IDLE=0, RUN=1, FAILED=2

Behaviour:
- Reset (sync, active-high, dominates all other inputs):
  - state=IDLE; both pipeline valid bits cleared.
  - All outputs 0.
- FSM:
  - IDLE→RUN when check_enable=1.
  - RUN→IDLE when check_enable=0. Both pipeline valids flush that cycle; no check_valid for in-flight packets.
  - RUN→FAILED when a stage-2 result fails and STOP_ON_FAIL=1.
  - FAILED→IDLE on check_clear only. check_enable is ignored in FAILED.
  - check_clear in IDLE/RUN clears the sticky outputs (failed_sticky, fail_insn, fail_ip, fail_mask) and goes to IDLE.
  - check_clear does not clear the counters.
- Accept:
  - A packet enters stage 1 only when state=RUN and z80fi_valid=1.
  - Packets in IDLE/FAILED are dropped and not counted.
- Stage 1 (cycle N+1):
  - Register the packet.
  - If spec_valid=0: skip_count += 1 (saturating at all-ones); no stage-2 entry.
- Per-register mismatch, r ∈ {IP,F,A}:
  - spec_chk[r]=1: core_out ≠ spec_out.
  - spec_chk[r]=0: core_out ≠ core_in (unwritten register must be unchanged).
  - Full-width bitwise compare; no masking of F bits 3/5.
- Stage 2 (cycle N+2):
  - check_valid=1; mismatch registered; check_fail = |mismatch.
  - check_count += 1 (saturating).
  - Back-to-back packets give back-to-back check_valid pulses; no stalls, throughput 1/cycle.
- First failure (failed_sticky=0):
  - Capture fail_insn, fail_ip, fail_mask; set failed_sticky.
  - Later failures do not overwrite (STOP_ON_FAIL=0).
- STOP_ON_FAIL=1:
  - On the failing cycle, the packet in stage 1 is discarded: no check_valid, not counted.
- Simultaneous events:
  - check_clear and a failing stage-2 result in the same cycle: clear wins; the result is still pulsed on check_valid/check_fail/mismatch but is not captured as sticky; state=IDLE.
  - check_enable falling while a failure is in stage 2: the result is flushed; no sticky capture.
- check_valid, check_fail, mismatch are 0 in every cycle without a result.

Test Plan:
- SCF pass:
  - Stimulus: RUN; insn=0x37, len=1, ip_in=0x1000, ip_out=0x1001, f_in=0x00, f_out=0x01, a_in=a_out=0x42; spec_valid=1, spec_chk=3'b011, spec_ip=0x1001, spec_f=0x01.
  - Required: at N+2, check_valid=1, check_fail=0, mismatch=0, check_count=1.
- SCF F fail:
  - Stimulus: same, but core f_out=0x11, spec_f=0x01.
  - Required: at N+2, check_fail=1, mismatch=3'b010, failed_sticky=1, fail_insn=0x37, fail_ip=0x1000, state=FAILED; a following packet produces no check_valid.
- Unwritten register changed:
  - Stimulus: spec_chk=3'b011, a_in=0x55, a_out=0x56, other fields match.
  - Required: mismatch=3'b100, check_fail=1.
- Skip and saturation (COUNT_W=4):
  - Stimulus: 20 consecutive packets with spec_valid=0.
  - Required: skip_count=15, check_count=0, no check_valid.
- STOP_ON_FAIL=0:
  - Stimulus: failures at ip_in 0x2000 then 0x3000.
  - Required: fail_ip=0x2000, state=RUN, check_count=2.
- Clear/flush:
  - Stimulus: check_clear coincident with a failing stage-2 result.
  - Required: check_fail pulse seen, failed_sticky=0, state=IDLE.
  - Stimulus: drop check_enable with 2 packets in flight.
  - Required: no check_valid.

Source files
------------

// File: rtl/z80fi_insn_check.sv
// Retired-instruction checker: compares the core's z80fi packet against a spec
// module's prediction through a two-stage pipeline, with sticky first-failure capture.
module z80fi_insn_check #(
    parameter int COUNT_W      = 16,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               check_enable,
    input  logic               check_clear,
    input  logic               z80fi_valid,
    input  logic [31:0]        z80fi_insn,
    input  logic [2:0]         z80fi_insn_len,
    input  logic [15:0]        z80fi_reg_ip_in,
    input  logic [15:0]        z80fi_reg_ip_out,
    input  logic [7:0]         z80fi_reg_f_in,
    input  logic [7:0]         z80fi_reg_f_out,
    input  logic [7:0]         z80fi_reg_a_in,
    input  logic [7:0]         z80fi_reg_a_out,
    input  logic               spec_valid,
    input  logic [2:0]         spec_chk,
    input  logic [15:0]        spec_reg_ip_out,
    input  logic [7:0]         spec_reg_f_out,
    input  logic [7:0]         spec_reg_a_out,
    output logic               check_valid,
    output logic               check_fail,
    output logic [2:0]         mismatch,
    output logic               failed_sticky,
    output logic [31:0]        fail_insn,
    output logic [15:0]        fail_ip,
    output logic [2:0]         fail_mask,
    output logic [COUNT_W-1:0] check_count,
    output logic [COUNT_W-1:0] skip_count,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FAILED = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_vld_p1;
    logic [31:0] r_insn_p1;
    logic [15:0] r_ip_p1;
    logic [2:0]  r_mis_p1;

    logic        w_flush;
    logic        w_s2_vld;
    logic        w_s2_fail;
    logic        w_stop;
    logic        w_accept;
    logic [2:0]  w_mis;
    logic        w_unused_len;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + {{(COUNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Instruction length carries no checkable state at this stage.
    assign w_unused_len = ^z80fi_insn_len;

    // A register the spec does not write must come out unchanged.
    assign w_mis[0] = spec_chk[0] ? (z80fi_reg_ip_out != spec_reg_ip_out)
                                  : (z80fi_reg_ip_out != z80fi_reg_ip_in);
    assign w_mis[1] = spec_chk[1] ? (z80fi_reg_f_out != spec_reg_f_out)
                                  : (z80fi_reg_f_out != z80fi_reg_f_in);
    assign w_mis[2] = spec_chk[2] ? (z80fi_reg_a_out != spec_reg_a_out)
                                  : (z80fi_reg_a_out != z80fi_reg_a_in);

    assign w_flush   = (r_state == ST_RUN) && !check_enable;
    assign w_s2_vld  = r_vld_p1 && !w_flush;
    assign w_s2_fail = w_s2_vld && (|r_mis_p1);
    assign w_stop    = w_s2_fail && STOP_ON_FAIL && !check_clear;
    assign w_accept  = (r_state == ST_RUN) && check_enable && !check_clear
                       && z80fi_valid && !w_stop;

    assign state = r_state;

    // Stage 1: register packet fields and mismatch vector
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_insn_p1 <= z80fi_insn;
            r_ip_p1   <= z80fi_reg_ip_in;
            r_mis_p1  <= w_mis;
        end
    end

    // Stage 2: result outputs, counters, sticky capture and FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_vld_p1      <= 1'b0;
            check_valid   <= 1'b0;
            check_fail    <= 1'b0;
            mismatch      <= 3'b000;
            failed_sticky <= 1'b0;
            fail_insn     <= 32'h0;
            fail_ip       <= 16'h0;
            fail_mask     <= 3'b000;
            check_count   <= '0;
            skip_count    <= '0;
        end else begin
            r_vld_p1    <= w_accept && spec_valid;
            check_valid <= w_s2_vld;
            check_fail  <= w_s2_fail;
            mismatch    <= w_s2_vld ? r_mis_p1 : 3'b000;

            if (w_s2_vld)
                check_count <= sat_inc(check_count);
            if (w_accept && !spec_valid)
                skip_count <= sat_inc(skip_count);

            if (check_clear) begin
                failed_sticky <= 1'b0;
                fail_insn     <= 32'h0;
                fail_ip       <= 16'h0;
                fail_mask     <= 3'b000;
            end else if (w_s2_fail && !failed_sticky) begin
                failed_sticky <= 1'b1;
                fail_insn     <= r_insn_p1;
                fail_ip       <= r_ip_p1;
                fail_mask     <= r_mis_p1;
            end

            if (check_clear) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE:   if (check_enable) r_state <= ST_RUN;
                    ST_RUN: begin
                        if (!check_enable)
                            r_state <= ST_IDLE;
                        else if (w_stop)
                            r_state <= ST_FAILED;
                    end
                    ST_FAILED: r_state <= ST_FAILED;
                    default:   r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_z80fi_insn_check.sv
// Directed bench for z80fi_insn_check: one stop-on-fail and one keep-going instance
// share stimulus; table vectors plus hand-written multi-cycle sequences.
module tb_z80fi_insn_check;

    logic        clk = 1'b0;
    logic        reset, check_enable, check_clear, z80fi_valid, spec_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len, spec_chk;
    logic [15:0] ip_in, ip_out, s_ip;
    logic [7:0]  f_in, f_out, a_in, a_out, s_f, s_a;

    logic        a_cv, a_cf, a_fs, b_cv, b_cf, b_fs;
    logic [2:0]  a_mis, a_fm, b_mis, b_fm;
    logic [31:0] a_fi, b_fi;
    logic [15:0] a_fip, b_fip;
    logic [3:0]  a_cc, a_sc, b_cc, b_sc;
    logic [1:0]  a_st, b_st;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    z80fi_insn_check #(.COUNT_W(4), .STOP_ON_FAIL(1'b1)) u_stop (
        .clk(clk), .reset(reset), .check_enable(check_enable), .check_clear(check_clear),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_reg_ip_in(ip_in), .z80fi_reg_ip_out(ip_out),
        .z80fi_reg_f_in(f_in), .z80fi_reg_f_out(f_out),
        .z80fi_reg_a_in(a_in), .z80fi_reg_a_out(a_out),
        .spec_valid(spec_valid), .spec_chk(spec_chk), .spec_reg_ip_out(s_ip),
        .spec_reg_f_out(s_f), .spec_reg_a_out(s_a),
        .check_valid(a_cv), .check_fail(a_cf), .mismatch(a_mis), .failed_sticky(a_fs),
        .fail_insn(a_fi), .fail_ip(a_fip), .fail_mask(a_fm),
        .check_count(a_cc), .skip_count(a_sc), .state(a_st));

    z80fi_insn_check #(.COUNT_W(4), .STOP_ON_FAIL(1'b0)) u_cont (
        .clk(clk), .reset(reset), .check_enable(check_enable), .check_clear(check_clear),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_reg_ip_in(ip_in), .z80fi_reg_ip_out(ip_out),
        .z80fi_reg_f_in(f_in), .z80fi_reg_f_out(f_out),
        .z80fi_reg_a_in(a_in), .z80fi_reg_a_out(a_out),
        .spec_valid(spec_valid), .spec_chk(spec_chk), .spec_reg_ip_out(s_ip),
        .spec_reg_f_out(s_f), .spec_reg_a_out(s_a),
        .check_valid(b_cv), .check_fail(b_cf), .mismatch(b_mis), .failed_sticky(b_fs),
        .fail_insn(b_fi), .fail_ip(b_fip), .fail_mask(b_fm),
        .check_count(b_cc), .skip_count(b_sc), .state(b_st));

    typedef struct {
        logic [31:0] insn;
        logic [15:0] ip_in, ip_out, s_ip;
        logic [7:0]  f_in, f_out, s_f, a_in, a_out, s_a;
        logic [2:0]  chk;
        logic [2:0]  exp_mis;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v, input logic sv);
        z80fi_valid = 1'b1;
        spec_valid  = sv;
        z80fi_insn  = v.insn;
        z80fi_insn_len = 3'd1;
        ip_in = v.ip_in;  ip_out = v.ip_out;  s_ip = v.s_ip;
        f_in  = v.f_in;   f_out  = v.f_out;   s_f  = v.s_f;
        a_in  = v.a_in;   a_out  = v.a_out;   s_a  = v.s_a;
        spec_chk = v.chk;
    endtask

    task automatic idle_in();
        z80fi_valid = 1'b0;
        spec_valid  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        check_enable = 1'b0;
        check_clear = 1'b0;
        idle_in();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic enable_run();
        check_enable = 1'b1;
        tick();
    endtask

    function automatic vec_t mk(input logic [15:0] ipi, input logic [7:0] fo, input logic [7:0] ai,
                                input logic [7:0] ao);
        vec_t v;
        v.insn = 32'h37; v.chk = 3'b011;
        v.ip_in = ipi; v.ip_out = ipi + 16'd1; v.s_ip = ipi + 16'd1;
        v.f_in = 8'h00; v.f_out = fo; v.s_f = 8'h01;
        v.a_in = ai; v.a_out = ao; v.s_a = 8'h00;
        v.exp_mis = 3'b000;
        return v;
    endfunction

    initial begin
        vec_t scf_pass, scf_fail, a_fail;

        // {insn, ip_in, ip_out, s_ip, f_in, f_out, s_f, a_in, a_out, s_a, chk, exp_mis}
        vecs[0] = '{32'h37, 16'h1000, 16'h1001, 16'h1001, 8'h00, 8'h01, 8'h01, 8'h42, 8'h42, 8'h00, 3'b011, 3'b000};
        vecs[1] = '{32'h37, 16'h1000, 16'h1001, 16'h1001, 8'h00, 8'h01, 8'h01, 8'h55, 8'h56, 8'h00, 3'b011, 3'b100};
        vecs[2] = '{32'h37, 16'h1000, 16'h1001, 16'h1002, 8'h00, 8'h01, 8'h01, 8'h42, 8'h42, 8'h00, 3'b011, 3'b001};
        vecs[3] = '{32'h3E20, 16'h0200, 16'h0202, 16'h0202, 8'h44, 8'h44, 8'h00, 8'h10, 8'h20, 8'h20, 3'b101, 3'b000};
        vecs[4] = '{32'h00, 16'h0300, 16'h0301, 16'h0301, 8'h00, 8'h08, 8'h00, 8'h11, 8'h11, 8'h00, 3'b001, 3'b010};
        vecs[5] = '{32'h3C, 16'h0400, 16'h0401, 16'h0402, 8'h00, 8'h28, 8'h00, 8'h01, 8'h02, 8'h03, 3'b111, 3'b111};

        do_reset();
        check("rst_state", {30'd0, a_st}, 32'd0);
        check("rst_valid", {31'd0, a_cv}, 32'd0);
        check("rst_sticky", {31'd0, a_fs}, 32'd0);
        check("rst_fail_insn", a_fi, 32'd0);
        check("rst_check_count", {28'd0, a_cc}, 32'd0);
        check("rst_skip_count", {28'd0, a_sc}, 32'd0);

        enable_run();
        check("run_state", {30'd0, a_st}, 32'd1);

        // Table vectors on the keep-going instance
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i], 1'b1);
            tick();
            idle_in();
            tick();
            check($sformatf("vec%0d_valid", i), {31'd0, b_cv}, 32'd1);
            check($sformatf("vec%0d_fail", i), {31'd0, b_cf}, {31'd0, |vecs[i].exp_mis});
            check($sformatf("vec%0d_mismatch", i), {29'd0, b_mis}, {29'd0, vecs[i].exp_mis});
            check($sformatf("vec%0d_count", i), {28'd0, b_cc}, i + 1);
        end
        tick();
        check("vec_valid_drops", {31'd0, b_cv}, 32'd0);
        check("vec_mismatch_idle", {29'd0, b_mis}, 32'd0);

        // SCF F failure, stop-on-fail, followed by back-to-back packets
        do_reset();
        enable_run();
        scf_pass = mk(16'h1001, 8'h01, 8'h42, 8'h42);
        scf_fail = mk(16'h1000, 8'h11, 8'h42, 8'h42);
        drive(scf_fail, 1'b1);
        tick();
        drive(scf_pass, 1'b1);
        tick();
        check("scf_fail_valid", {31'd0, a_cv}, 32'd1);
        check("scf_fail_fail", {31'd0, a_cf}, 32'd1);
        check("scf_fail_mismatch", {29'd0, a_mis}, 32'd2);
        check("scf_fail_sticky", {31'd0, a_fs}, 32'd1);
        check("scf_fail_insn", a_fi, 32'h37);
        check("scf_fail_ip", {16'd0, a_fip}, 32'h1000);
        check("scf_fail_mask", {29'd0, a_fm}, 32'd2);
        check("scf_fail_state", {30'd0, a_st}, 32'd2);
        scf_pass = mk(16'h1002, 8'h01, 8'h42, 8'h42);
        drive(scf_pass, 1'b1);
        tick();
        check("stop_no_valid", {31'd0, a_cv}, 32'd0);
        check("cont_b2b_valid", {31'd0, b_cv}, 32'd1);
        idle_in();
        tick();
        check("stop_no_valid2", {31'd0, a_cv}, 32'd0);
        check("stop_count", {28'd0, a_cc}, 32'd1);
        check("cont_count", {28'd0, b_cc}, 32'd3);
        check_enable = 1'b0;
        tick();
        check("failed_ignores_enable", {30'd0, a_st}, 32'd2);
        check_clear = 1'b1;
        tick();
        check_clear = 1'b0;
        check("clear_state", {30'd0, a_st}, 32'd0);
        check("clear_sticky", {31'd0, a_fs}, 32'd0);
        check("clear_fail_ip", {16'd0, a_fip}, 32'd0);
        check("clear_keeps_count", {28'd0, a_cc}, 32'd1);

        // Keep-going: two failures, first one latched
        do_reset();
        enable_run();
        drive(mk(16'h2000, 8'h01, 8'h55, 8'h56), 1'b1);
        tick();
        drive(mk(16'h3000, 8'h11, 8'h00, 8'h00), 1'b1);
        tick();
        idle_in();
        tick();
        tick();
        check("nostop_fail_ip", {16'd0, b_fip}, 32'h2000);
        check("nostop_fail_mask", {29'd0, b_fm}, 32'd4);
        check("nostop_state", {30'd0, b_st}, 32'd1);
        check("nostop_count", {28'd0, b_cc}, 32'd2);

        // Clear coincident with a failing stage-2 result
        do_reset();
        enable_run();
        a_fail = mk(16'h4000, 8'h01, 8'h55, 8'h56);
        drive(a_fail, 1'b1);
        tick();
        idle_in();
        check_clear = 1'b1;
        tick();
        check_clear = 1'b0;
        check("clr_coinc_valid", {31'd0, a_cv}, 32'd1);
        check("clr_coinc_fail", {31'd0, a_cf}, 32'd1);
        check("clr_coinc_sticky", {31'd0, a_fs}, 32'd0);
        check("clr_coinc_state", {30'd0, a_st}, 32'd0);

        // Enable drop with packets in flight
        do_reset();
        enable_run();
        drive(a_fail, 1'b1);
        tick();
        drive(mk(16'h4001, 8'h01, 8'h55, 8'h56), 1'b1);
        check_enable = 1'b0;
        tick();
        check("flush_no_valid", {31'd0, a_cv}, 32'd0);
        check("flush_state", {30'd0, a_st}, 32'd0);
        idle_in();
        tick();
        check("flush_no_valid2", {31'd0, a_cv}, 32'd0);
        check("flush_count", {28'd0, a_cc}, 32'd0);
        check("flush_sticky", {31'd0, a_fs}, 32'd0);

        // Skip counting and saturation
        do_reset();
        enable_run();
        for (int i = 0; i < 20; i++) begin
            drive(mk(16'h5000, 8'h01, 8'h00, 8'h00), 1'b0);
            tick();
            if (i == 2)
                check("skip_after3", {28'd0, a_sc}, 32'd3);
            check($sformatf("skip%0d_no_valid", i), {31'd0, a_cv}, 32'd0);
        end
        idle_in();
        tick();
        check("skip_saturated", {28'd0, a_sc}, 32'd15);
        check("skip_check_count", {28'd0, a_cc}, 32'd0);
        check("skip_no_valid_tail", {31'd0, a_cv}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
